// File: rtl/ofdm_pkg.sv
// ---------------------------------------------------------------------------
// ofdm_pkg
// Shared types and default constants for the OFDM cyclic-prefix remover.
//   ITEM_W_DEF     : default sample width (sc16, I in [31:16], Q in [15:0])
//   MAX_LOG2_K_DEF : default log2 of the largest FFT size
//   CNT_W_DEF      : default width of FFT-size / CP-length fields and counters
//   item_t, cnt_t  : sample and counter types at the default widths
//   cp_state_t     : control FSM states
// ---------------------------------------------------------------------------
package ofdm_pkg;

    localparam int ITEM_W_DEF     = 32;
    localparam int MAX_LOG2_K_DEF = 12;
    localparam int CNT_W_DEF      = MAX_LOG2_K_DEF + 1;

    typedef logic [ITEM_W_DEF-1:0] item_t;
    typedef logic [CNT_W_DEF-1:0]  cnt_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CP_DROP = 2'd1,
        BODY    = 2'd2
    } cp_state_t;

endpackage

// File: rtl/ofdm_axis_out_reg.sv
// ---------------------------------------------------------------------------
// ofdm_axis_out_reg
// One-stage AXI-stream output register carrying {tdata, tuser, tlast}.
// Ports:
//   clk, srst           : clock, synchronous active-high reset
//   load_i              : upstream presents a beat to capture
//   data_i/user_i/last_i: beat contents
//   ready_o             : register can take a beat this cycle
//   m_valid_o/m_data_o/m_user_o/m_last_o : downstream stream
//   m_ready_i           : downstream ready
// ---------------------------------------------------------------------------
module ofdm_axis_out_reg
    import ofdm_pkg::*;
#(
    parameter int ITEM_W = ITEM_W_DEF
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              load_i,
    input  logic [ITEM_W-1:0] data_i,
    input  logic              user_i,
    input  logic              last_i,
    output logic              ready_o,
    output logic              m_valid_o,
    output logic [ITEM_W-1:0] m_data_o,
    output logic              m_user_o,
    output logic              m_last_o,
    input  logic              m_ready_i
);

    logic              valid_q;
    logic [ITEM_W-1:0] data_q;
    logic              user_q;
    logic              last_q;

    // Full throughput: a new beat may replace the held one in the same cycle
    // it is consumed downstream.
    assign ready_o = !valid_q || m_ready_i;

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            user_q  <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_i && ready_o) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            user_q  <= user_i;
            last_q  <= last_i;
        end else if (m_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign m_valid_o = valid_q;
    assign m_data_o  = data_q;
    assign m_user_o  = user_q;
    assign m_last_o  = last_q;

endmodule

// File: rtl/ofdm_cp_remover.sv
// ---------------------------------------------------------------------------
// ofdm_cp_remover
// Strips the cyclic prefix of every OFDM symbol in a frame and forwards
// exactly K body samples per symbol, tlast on each symbol's last sample,
// tuser on the first output sample of the frame. Samples outside a frame
// are dropped.
// Ports:
//   ce_clk, ce_rst         : clock, synchronous active-high reset
//   cfg_fft_size           : K (1..2^MAX_LOG2_K), latched at SOF
//   cfg_cp_len             : payload CP length (0..K), latched at SOF
//   cfg_cp_pre_len         : preamble CP length (0..K), latched at SOF
//   cfg_num_sym            : symbols per frame (0 treated as 1), latched at SOF
//   s_axis_*               : input sample stream, tuser = start of frame
//   m_axis_*               : output sample stream
//   sof_dropped            : pulse after a tuser beat accepted mid-frame
//   busy                   : FSM not idle
// ---------------------------------------------------------------------------
module ofdm_cp_remover
    import ofdm_pkg::*;
#(
    parameter int ITEM_W     = ITEM_W_DEF,
    parameter int MAX_LOG2_K = MAX_LOG2_K_DEF,
    parameter int CNT_W      = MAX_LOG2_K + 1
) (
    input  logic              ce_clk,
    input  logic              ce_rst,
    input  logic [CNT_W-1:0]  cfg_fft_size,
    input  logic [CNT_W-1:0]  cfg_cp_len,
    input  logic [CNT_W-1:0]  cfg_cp_pre_len,
    input  logic [7:0]        cfg_num_sym,
    input  logic [ITEM_W-1:0] s_axis_tdata,
    input  logic              s_axis_tuser,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [ITEM_W-1:0] m_axis_tdata,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              sof_dropped,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    cp_state_t        state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] cp_len_q, cp_len_d;
    logic [CNT_W-1:0] cur_cp_q, cur_cp_d;
    logic [CNT_W-1:0] cp_cnt_q, cp_cnt_d;
    logic [CNT_W-1:0] body_cnt_q, body_cnt_d;
    logic [7:0]       sym_idx_q, sym_idx_d;
    logic [7:0]       last_sym_q, last_sym_d;
    logic             sof_drop_q, sof_drop_d;

    logic             accept;
    logic             out_ready;
    logic             body_beat;
    logic             body_last;
    logic             body_first;
    logic [CNT_W-1:0] k_eff;
    logic [CNT_W-1:0] cp_len_eff;
    logic [7:0]       last_sym_eff;
    logic [7:0]       last_sym_cfg;
    logic [CNT_W-1:0] bc;
    logic [7:0]       si;

    assign accept       = s_axis_tvalid && s_axis_tready;
    assign last_sym_cfg = (cfg_num_sym == 8'd0) ? 8'd0 : cfg_num_sym - 8'd1;

    // The SOF beat in IDLE is judged against the live cfg values, which are
    // the ones being latched on that same beat.
    always_comb begin
        if (state_q == IDLE) begin
            k_eff        = cfg_fft_size;
            cp_len_eff   = cfg_cp_len;
            last_sym_eff = last_sym_cfg;
            bc           = '0;
            si           = 8'd0;
        end else begin
            k_eff        = k_q;
            cp_len_eff   = cp_len_q;
            last_sym_eff = last_sym_q;
            bc           = body_cnt_q;
            si           = sym_idx_q;
        end
    end

    // A body beat is any BODY-state beat, or a SOF beat with a zero-length
    // preamble CP (that beat is already body sample 0).
    assign body_beat  = (state_q == BODY) ||
                        ((state_q == IDLE) && s_axis_tuser && (cfg_cp_pre_len == '0));
    assign body_last  = (bc == k_eff - CNT_ONE);
    assign body_first = (si == 8'd0) && (bc == '0);

    // State register
    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            cp_len_q   <= '0;
            cur_cp_q   <= '0;
            cp_cnt_q   <= '0;
            body_cnt_q <= '0;
            sym_idx_q  <= 8'd0;
            last_sym_q <= 8'd0;
            sof_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cp_len_q   <= cp_len_d;
            cur_cp_q   <= cur_cp_d;
            cp_cnt_q   <= cp_cnt_d;
            body_cnt_q <= body_cnt_d;
            sym_idx_q  <= sym_idx_d;
            last_sym_q <= last_sym_d;
            sof_drop_q <= sof_drop_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cp_len_d   = cp_len_q;
        cur_cp_d   = cur_cp_q;
        cp_cnt_d   = cp_cnt_q;
        body_cnt_d = body_cnt_q;
        sym_idx_d  = sym_idx_q;
        last_sym_d = last_sym_q;
        sof_drop_d = 1'b0;

        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (s_axis_tuser) begin
                        k_d        = cfg_fft_size;
                        cp_len_d   = cfg_cp_len;
                        last_sym_d = last_sym_cfg;
                        cur_cp_d   = cfg_cp_pre_len;
                        sym_idx_d  = 8'd0;
                        if (cfg_cp_pre_len == CNT_ONE) begin
                            state_d    = BODY;
                            body_cnt_d = '0;
                        end else if (cfg_cp_pre_len != '0) begin
                            state_d  = CP_DROP;
                            cp_cnt_d = CNT_ONE;
                        end
                    end
                end
                CP_DROP: begin
                    sof_drop_d = s_axis_tuser;
                    if (cp_cnt_q == cur_cp_q - CNT_ONE) begin
                        state_d    = BODY;
                        body_cnt_d = '0;
                    end else begin
                        cp_cnt_d = cp_cnt_q + CNT_ONE;
                    end
                end
                BODY: begin
                    sof_drop_d = s_axis_tuser;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (body_beat) begin
                if (body_last) begin
                    body_cnt_d = '0;
                    cp_cnt_d   = '0;
                    if (si == last_sym_eff) begin
                        state_d = IDLE;
                    end else begin
                        sym_idx_d = si + 8'd1;
                        cur_cp_d  = cp_len_eff;
                        state_d   = (cp_len_eff == '0) ? BODY : CP_DROP;
                    end
                end else begin
                    body_cnt_d = bc + CNT_ONE;
                    state_d    = BODY;
                end
            end
        end
    end

    // Output logic. A SOF with zero preamble CP emits immediately, so in IDLE
    // that beat has to wait for the output register just like a BODY beat.
    always_comb begin
        s_axis_tready = 1'b1;
        case (state_q)
            IDLE:    s_axis_tready = (cfg_cp_pre_len != '0) || out_ready;
            BODY:    s_axis_tready = out_ready;
            default: s_axis_tready = 1'b1;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign sof_dropped = sof_drop_q;

    ofdm_axis_out_reg #(
        .ITEM_W (ITEM_W)
    ) u_out_reg (
        .clk       (ce_clk),
        .srst      (ce_rst),
        .load_i    (accept && body_beat),
        .data_i    (s_axis_tdata),
        .user_i    (body_first),
        .last_i    (body_last),
        .ready_o   (out_ready),
        .m_valid_o (m_axis_tvalid),
        .m_data_o  (m_axis_tdata),
        .m_user_o  (m_axis_tuser),
        .m_last_o  (m_axis_tlast),
        .m_ready_i (m_axis_tready)
    );

endmodule

// File: tb/tb_ofdm_cp_remover.sv
module tb_ofdm_cp_remover;

    localparam int ITEM_W = 32;
    localparam int CNT_W  = 13;

    logic              ce_clk = 1'b0;
    logic              ce_rst = 1'b1;
    logic [CNT_W-1:0]  cfg_fft_size   = '0;
    logic [CNT_W-1:0]  cfg_cp_len     = '0;
    logic [CNT_W-1:0]  cfg_cp_pre_len = '0;
    logic [7:0]        cfg_num_sym    = '0;
    logic [ITEM_W-1:0] s_axis_tdata   = '0;
    logic              s_axis_tuser   = 1'b0;
    logic              s_axis_tvalid  = 1'b0;
    logic              s_axis_tready;
    logic [ITEM_W-1:0] m_axis_tdata;
    logic              m_axis_tuser;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready  = 1'b1;
    logic              sof_dropped;
    logic              busy;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 ce_clk = ~ce_clk;

    ofdm_cp_remover dut (
        .ce_clk         (ce_clk),
        .ce_rst         (ce_rst),
        .cfg_fft_size   (cfg_fft_size),
        .cfg_cp_len     (cfg_cp_len),
        .cfg_cp_pre_len (cfg_cp_pre_len),
        .cfg_num_sym    (cfg_num_sym),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .sof_dropped    (sof_dropped),
        .busy           (busy)
    );

    // Captured output beats and the expected stream
    int cap_data[$];
    bit cap_user[$];
    bit cap_last[$];
    int exp_data[$];
    bit exp_user[$];
    bit exp_last[$];
    int stall_err = 0;
    int sof_cnt   = 0;
    bit prev_stall = 1'b0;
    logic [ITEM_W+1:0] prev_beat = '0;

    // Inputs change 1 time unit after the rising edge, so the falling edge
    // sees the values that the next rising edge will act on.
    always @(negedge ce_clk) begin
        if (!ce_rst) begin
            if (m_axis_tvalid && m_axis_tready) begin
                cap_data.push_back(int'(m_axis_tdata));
                cap_user.push_back(m_axis_tuser);
                cap_last.push_back(m_axis_tlast);
            end
            if (prev_stall && (!m_axis_tvalid ||
                {m_axis_tdata, m_axis_tuser, m_axis_tlast} !== prev_beat))
                stall_err++;
            if (sof_dropped)
                sof_cnt++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat  = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_q();
        cap_data.delete(); cap_user.delete(); cap_last.delete();
        exp_data.delete(); exp_user.delete(); exp_last.delete();
        stall_err = 0;
        sof_cnt   = 0;
    endtask

    task automatic set_cfg(input int k, input int cp, input int cpp, input int ns);
        cfg_fft_size   = CNT_W'(k);
        cfg_cp_len     = CNT_W'(cp);
        cfg_cp_pre_len = CNT_W'(cpp);
        cfg_num_sym    = 8'(ns);
    endtask

    task automatic add_seg(input int lo, input int hi, input bit u, input bit l);
        for (int v = lo; v <= hi; v++) begin
            exp_data.push_back(v);
            exp_user.push_back(u && (v == lo));
            exp_last.push_back(l && (v == hi));
        end
    endtask

    // Sends values first..first+n-1; tuser on values sof_a / sof_b.
    task automatic drive_seq(input int first, input int n, input int sof_a,
                             input int sof_b, input bit stall);
        int v;
        int guard;
        bit hs;
        v = first;
        guard = 0;
        while (v < first + n) begin
            if (!s_axis_tvalid) begin
                if (stall && ($urandom_range(0, 1) == 0)) begin
                    s_axis_tuser = 1'b0;
                end else begin
                    s_axis_tvalid = 1'b1;
                    s_axis_tdata  = ITEM_W'(v);
                    s_axis_tuser  = (v == sof_a) || (v == sof_b);
                end
            end
            @(negedge ce_clk);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge ce_clk);
            #1;
            if (hs) begin
                v++;
                s_axis_tvalid = 1'b0;
                s_axis_tuser  = 1'b0;
            end
            m_axis_tready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            guard++;
            if (guard > 5000) begin
                tests_run++;
                tests_failed++;
                $display("FAIL drive_timeout: stuck at value %0d, expected progress within 5000 cycles", v);
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic drain();
        m_axis_tready = 1'b1;
        repeat (6) @(posedge ce_clk);
        #1;
    endtask

    task automatic test_reset();
        ce_rst = 1'b1;
        repeat (3) @(posedge ce_clk);
        #1;
        ce_rst = 1'b0;
        @(posedge ce_clk);
        #1;
        tests_run++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tuser !== 1'b0 || m_axis_tlast !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got valid=%b user=%b last=%b, expected 0 0 0",
                     m_axis_tvalid, m_axis_tuser, m_axis_tlast);
        end
        tests_run++;
        if (m_axis_tdata !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: got %0h, expected 0", m_axis_tdata);
        end
        tests_run++;
        if (sof_dropped !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_status: got sof_dropped=%b busy=%b, expected 0 0", sof_dropped, busy);
        end
        tests_run++;
        if (s_axis_tready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_tready: got %b, expected 1", s_axis_tready);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic();
        clear_q();
        set_cfg(16, 4, 8, 3);
        add_seg(108, 123, 1'b1, 1'b1);
        add_seg(128, 143, 1'b0, 1'b1);
        add_seg(148, 163, 1'b0, 1'b1);
        drive_seq(100, 100, 100, -1, 1'b0);
        drain();
        tests_run++;
        if (cap_data.size() != exp_data.size()) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d beats, expected %0d", cap_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            tests_run++;
            if ({cap_data[i], cap_user[i], cap_last[i]} !== {exp_data[i], exp_user[i], exp_last[i]}) begin
                tests_failed++;
                $display("FAIL basic_beat%0d: got data=%0d user=%b last=%b, expected data=%0d user=%b last=%b",
                         i, cap_data[i], cap_user[i], cap_last[i], exp_data[i], exp_user[i], exp_last[i]);
            end
        end
        tests_run++;
        if (sof_cnt != 0) begin
            tests_failed++;
            $display("FAIL basic_sof_dropped: got %0d pulses, expected 0", sof_cnt);
        end
        $display("[TB] test_basic: %0d beats captured", cap_data.size());
    endtask

    task automatic test_zero_cp();
        clear_q();
        set_cfg(8, 0, 0, 2);
        add_seg(0, 7, 1'b1, 1'b1);
        add_seg(8, 15, 1'b0, 1'b1);
        drive_seq(0, 20, 0, -1, 1'b0);
        drain();
        tests_run++;
        if (cap_data.size() != exp_data.size()) begin
            tests_failed++;
            $display("FAIL zero_cp_count: got %0d beats, expected %0d", cap_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            tests_run++;
            if ({cap_data[i], cap_user[i], cap_last[i]} !== {exp_data[i], exp_user[i], exp_last[i]}) begin
                tests_failed++;
                $display("FAIL zero_cp_beat%0d: got data=%0d user=%b last=%b, expected data=%0d user=%b last=%b",
                         i, cap_data[i], cap_user[i], cap_last[i], exp_data[i], exp_user[i], exp_last[i]);
            end
        end
        $display("[TB] test_zero_cp: %0d beats captured", cap_data.size());
    endtask

    task automatic test_k1();
        clear_q();
        set_cfg(1, 0, 1, 3);
        add_seg(1, 1, 1'b1, 1'b1);
        add_seg(2, 2, 1'b0, 1'b1);
        add_seg(3, 3, 1'b0, 1'b1);
        drive_seq(0, 6, 0, -1, 1'b0);
        drain();
        tests_run++;
        if (cap_data.size() != exp_data.size()) begin
            tests_failed++;
            $display("FAIL k1_count: got %0d beats, expected %0d", cap_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            tests_run++;
            if ({cap_data[i], cap_user[i], cap_last[i]} !== {exp_data[i], exp_user[i], exp_last[i]}) begin
                tests_failed++;
                $display("FAIL k1_beat%0d: got data=%0d user=%b last=%b, expected data=%0d user=%b last=%b",
                         i, cap_data[i], cap_user[i], cap_last[i], exp_data[i], exp_user[i], exp_last[i]);
            end
        end
        $display("[TB] test_k1: %0d beats captured", cap_data.size());
    endtask

    task automatic test_backpressure();
        clear_q();
        set_cfg(16, 4, 8, 3);
        add_seg(108, 123, 1'b1, 1'b1);
        add_seg(128, 143, 1'b0, 1'b1);
        add_seg(148, 163, 1'b0, 1'b1);
        drive_seq(100, 100, 100, -1, 1'b1);
        drain();
        tests_run++;
        if (cap_data.size() != exp_data.size()) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d beats, expected %0d", cap_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            tests_run++;
            if ({cap_data[i], cap_user[i], cap_last[i]} !== {exp_data[i], exp_user[i], exp_last[i]}) begin
                tests_failed++;
                $display("FAIL bp_beat%0d: got data=%0d user=%b last=%b, expected data=%0d user=%b last=%b",
                         i, cap_data[i], cap_user[i], cap_last[i], exp_data[i], exp_user[i], exp_last[i]);
            end
        end
        tests_run++;
        if (stall_err != 0) begin
            tests_failed++;
            $display("FAIL bp_stable: got %0d unstable stall cycles, expected 0", stall_err);
        end
        $display("[TB] test_backpressure: %0d beats captured", cap_data.size());
    endtask

    task automatic test_spurious_sof();
        clear_q();
        set_cfg(16, 4, 8, 3);
        add_seg(108, 123, 1'b1, 1'b1);
        add_seg(128, 143, 1'b0, 1'b1);
        add_seg(148, 163, 1'b0, 1'b1);
        drive_seq(100, 63, 100, 130, 1'b0);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL spur_busy_before: got %b, expected 1", busy);
        end
        drive_seq(163, 1, -1, -1, 1'b0);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL spur_busy_after: got %b, expected 0", busy);
        end
        drive_seq(164, 36, -1, -1, 1'b0);
        drain();
        tests_run++;
        if (cap_data.size() != exp_data.size()) begin
            tests_failed++;
            $display("FAIL spur_count: got %0d beats, expected %0d", cap_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            tests_run++;
            if ({cap_data[i], cap_user[i], cap_last[i]} !== {exp_data[i], exp_user[i], exp_last[i]}) begin
                tests_failed++;
                $display("FAIL spur_beat%0d: got data=%0d user=%b last=%b, expected data=%0d user=%b last=%b",
                         i, cap_data[i], cap_user[i], cap_last[i], exp_data[i], exp_user[i], exp_last[i]);
            end
        end
        tests_run++;
        if (sof_cnt != 1) begin
            tests_failed++;
            $display("FAIL spur_sof_dropped: got %0d pulses, expected 1", sof_cnt);
        end
        $display("[TB] test_spurious_sof: %0d beats, %0d sof_dropped pulses", cap_data.size(), sof_cnt);
    endtask

    task automatic test_back_to_back();
        clear_q();
        set_cfg(16, 4, 8, 3);
        add_seg(108, 123, 1'b1, 1'b1);
        add_seg(128, 143, 1'b0, 1'b1);
        add_seg(148, 163, 1'b0, 1'b1);
        add_seg(172, 187, 1'b1, 1'b1);
        add_seg(192, 207, 1'b0, 1'b1);
        add_seg(212, 227, 1'b0, 1'b1);
        drive_seq(100, 140, 100, 164, 1'b0);
        drain();
        tests_run++;
        if (cap_data.size() != exp_data.size()) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d beats, expected %0d", cap_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            tests_run++;
            if ({cap_data[i], cap_user[i], cap_last[i]} !== {exp_data[i], exp_user[i], exp_last[i]}) begin
                tests_failed++;
                $display("FAIL b2b_beat%0d: got data=%0d user=%b last=%b, expected data=%0d user=%b last=%b",
                         i, cap_data[i], cap_user[i], cap_last[i], exp_data[i], exp_user[i], exp_last[i]);
            end
        end
        tests_run++;
        if (sof_cnt != 0) begin
            tests_failed++;
            $display("FAIL b2b_sof_dropped: got %0d pulses, expected 0", sof_cnt);
        end
        $display("[TB] test_back_to_back: %0d beats captured", cap_data.size());
    endtask

    task automatic test_reset_mid_frame();
        clear_q();
        set_cfg(16, 4, 8, 3);
        add_seg(108, 114, 1'b1, 1'b0);
        add_seg(208, 223, 1'b1, 1'b1);
        add_seg(228, 243, 1'b0, 1'b1);
        add_seg(248, 263, 1'b0, 1'b1);
        drive_seq(100, 16, 100, -1, 1'b0);
        tests_run++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd115) begin
            tests_failed++;
            $display("FAIL rst_pending: got valid=%b data=%0d, expected valid=1 data=115",
                     m_axis_tvalid, m_axis_tdata);
        end
        ce_rst = 1'b1;
        @(posedge ce_clk);
        #1;
        ce_rst = 1'b0;
        tests_run++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_state: got valid=%b busy=%b, expected 0 0", m_axis_tvalid, busy);
        end
        drive_seq(116, 15, -1, -1, 1'b0);
        drain();
        tests_run++;
        if (cap_data.size() != 7) begin
            tests_failed++;
            $display("FAIL rst_no_output: got %0d beats, expected 7", cap_data.size());
        end
        drive_seq(200, 100, 200, -1, 1'b0);
        drain();
        tests_run++;
        if (cap_data.size() != exp_data.size()) begin
            tests_failed++;
            $display("FAIL rst_count: got %0d beats, expected %0d", cap_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            tests_run++;
            if ({cap_data[i], cap_user[i], cap_last[i]} !== {exp_data[i], exp_user[i], exp_last[i]}) begin
                tests_failed++;
                $display("FAIL rst_beat%0d: got data=%0d user=%b last=%b, expected data=%0d user=%b last=%b",
                         i, cap_data[i], cap_user[i], cap_last[i], exp_data[i], exp_user[i], exp_last[i]);
            end
        end
        $display("[TB] test_reset_mid_frame: %0d beats captured", cap_data.size());
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_cp();
        test_k1();
        test_backpressure();
        test_spurious_sof();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
